// File: rtl/oam_dma.sv
// oam_dma: NES sprite DMA; on a CPU write to $4014 it stalls the CPU and copies
// page $XX00-$XXFF into PPU $2004 with alternating get/put cycles.
module oam_dma (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rw,
    input  logic [7:0]  cpu_data_o,
    input  logic [7:0]  bus_data_i,
    output logic [15:0] bus_addr,
    output logic        bus_rw,
    output logic [7:0]  bus_data_o,
    output logic        cpu_rdy,
    output logic        dma_active
);
    typedef enum logic [2:0] {IDLE, WAIT, ALIGN, READ, WRITE} state_t;
    state_t state, state_nx;
    logic [7:0] page, idx;
    logic parity;
    logic trig;
    assign trig = !cpu_rw && cpu_addr == 16'h4014;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end
    // parity free-runs from reset; 0 marks a get cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            page <= 8'h00;
            idx <= 8'h00;
            parity <= 1'b0;
        end else begin
            parity <= !parity;
            if (state == IDLE && trig) begin
                page <= cpu_data_o;
                idx <= 8'h00;
            end else if (state == WRITE && idx != 8'hFF) idx <= idx + 8'd1;
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = trig ? WAIT : IDLE;
            WAIT:    state_nx = !cpu_rw ? WAIT : parity ? READ : ALIGN;
            ALIGN:   state_nx = READ;
            READ:    state_nx = WRITE;
            WRITE:   state_nx = idx == 8'hFF ? IDLE : READ;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        bus_addr = state == READ ? {page, idx} : state == WRITE ? 16'h2004 : cpu_addr;
        bus_rw = state == READ ? 1'b1 : state == WRITE ? 1'b0 : cpu_rw;
        bus_data_o = state == WRITE ? bus_data_i : cpu_data_o;
        cpu_rdy = state == IDLE;
        dma_active = state == ALIGN || state == READ || state == WRITE || (state == WAIT && cpu_rw);
    end
endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed vectors and full-transfer sequences for oam_dma against a simple bus memory.
module tb_oam_dma;
    logic        clk, rst;
    logic [15:0] cpu_addr;
    logic        cpu_rw;
    logic [7:0]  cpu_data_o, bus_data_i;
    logic [15:0] bus_addr;
    logic        bus_rw;
    logic [7:0]  bus_data_o;
    logic        cpu_rdy, dma_active;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    oam_dma dut (
        .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_rw(cpu_rw),
        .cpu_data_o(cpu_data_o), .bus_data_i(bus_data_i), .bus_addr(bus_addr),
        .bus_rw(bus_rw), .bus_data_o(bus_data_o), .cpu_rdy(cpu_rdy), .dma_active(dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM $02nn = nn, cart $80nn = ~nn; data returned the cycle after the address
    function automatic logic [7:0] mem(input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        return a[15:8] == 8'h02 ? lo : a[15:8] == 8'h80 ? ~lo : 8'hEE;
    endfunction
    always @(posedge clk) bus_data_i <= mem(bus_addr);
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic idle_cycle();
        cpu_addr = 16'h8000;
        cpu_rw = 1'b1;
        cpu_data_o = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic run_dma(input logic [7:0] pg, input int extra, input bit hp, input int abort_at);
        int stall, writes, bad, off, m, n;
        logic [15:0] ea;
        logic erw;
        logic [7:0] ed;
        bit aborted;
        while ((cyc + 1 + extra) % 2 != int'(hp)) idle_cycle();
        cpu_addr = 16'h4014;
        cpu_rw = 1'b0;
        cpu_data_o = pg;
        @(negedge clk);
        check("trig_rdy", {cpu_rdy, dma_active}, 2'b10);
        @(posedge clk);
        #1;
        stall = 0;
        bad = 0;
        writes = 0;
        aborted = 0;
        for (int e = 0; e < extra; e++) begin
            cpu_addr = 16'h01FD - 16'(e);
            cpu_rw = 1'b0;
            cpu_data_o = 8'h55 + 8'(e);
            @(negedge clk);
            stall += int'(!cpu_rdy);
            if (cpu_rdy !== 0 || dma_active !== 0 || bus_addr !== cpu_addr || bus_rw !== 0 || bus_data_o !== cpu_data_o) bad++;
            @(posedge clk);
            #1;
        end
        cpu_addr = 16'hC123;
        cpu_rw = 1'b1;
        off = hp ? 1 : 2;
        for (int k = 0; k < off + 512; k++) begin
            @(negedge clk);
            m = k - off;
            n = m / 2;
            ed = pg == 8'h80 ? ~8'(n) : 8'(n);
            if (k < off) begin
                ea = cpu_addr;
                erw = 1'b1;
            end else if (m % 2 == 0) begin
                ea = {pg, 8'(n)};
                erw = 1'b1;
            end else begin
                ea = 16'h2004;
                erw = 1'b0;
            end
            if (cpu_rdy !== 0 || dma_active !== 1 || bus_addr !== ea || bus_rw !== erw) bad++;
            if (k >= off && m % 2 == 1 && bus_data_o !== ed) bad++;
            if (bus_addr === 16'h2004 && bus_rw === 1'b0) writes++;
            stall += int'(!cpu_rdy);
            if (abort_at != 0 && writes == abort_at) begin
                aborted = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        check("seq", bad, 0);
        if (aborted) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            @(negedge clk);
            check("abort_out", {cpu_rdy, dma_active, bus_rw, bus_addr}, {3'b101, 16'hC123});
            @(posedge clk);
            #1;
            rst = 1'b0;
            cpu_addr = 16'h0300;
            cpu_rw = 1'b0;
            cpu_data_o = 8'h77;
            @(negedge clk);
            check("abort_pass", {cpu_rdy, dma_active, bus_rw, bus_addr, bus_data_o}, {3'b100, 16'h0300, 8'h77});
            check("abort_writes", writes, abort_at);
        end else begin
            @(negedge clk);
            check("resume", {cpu_rdy, dma_active, bus_rw, bus_addr}, {3'b101, 16'hC123});
            check("stall", stall, extra + (hp ? 513 : 514));
            check("writes", writes, 256);
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  din;
        logic        rdy;
        logic        act;
    } vec_t;
    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h8000, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{16'h4015, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[2] = '{16'hC014, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{16'h4014, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{16'h4013, 1'b0, 8'h5A, 1'b1, 1'b0};
        vecs[5] = '{16'h0200, 1'b0, 8'hA5, 1'b1, 1'b0};
        vecs[6] = '{16'h2004, 1'b1, 8'h3C, 1'b1, 1'b0};
        rst = 1'b1;
        cpu_addr = 16'h1234;
        cpu_rw = 1'b0;
        cpu_data_o = 8'h9C;
        @(negedge clk);
        check("rst_ctl", {cpu_rdy, dma_active}, 2'b10);
        check("rst_bus", {bus_rw, bus_addr, bus_data_o}, {1'b0, 16'h1234, 8'h9C});
        @(posedge clk);
        #1;
        rst = 1'b0;
        foreach (vecs[i]) begin
            cpu_addr = vecs[i].addr;
            cpu_rw = vecs[i].rw;
            cpu_data_o = vecs[i].din;
            @(negedge clk);
            check($sformatf("vec%0d_ctl", i), {cpu_rdy, dma_active}, {vecs[i].rdy, vecs[i].act});
            check($sformatf("vec%0d_bus", i), {bus_rw, bus_addr, bus_data_o}, {vecs[i].rw, vecs[i].addr, vecs[i].din});
            @(posedge clk);
            #1;
        end
        run_dma(8'h02, 0, 1'b1, 0);
        run_dma(8'h02, 0, 1'b0, 0);
        run_dma(8'h02, 2, 1'b1, 0);
        run_dma(8'h80, 0, 1'b0, 0);
        run_dma(8'h02, 0, 1'b1, 100);
        run_dma(8'h02, 1, 1'b0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/oam_dma.md
# oam_dma

Sprite OAM DMA controller for the NES CPU bus. It decodes the CPU write to $4014, stalls the CPU through its RDY input, and takes ownership of the CPU-side bus. It then copies 256 bytes from CPU page $XX00–$XXFF into PPU register $2004, using alternating read/write cycles with NES-accurate halt and alignment timing. It sits between the 6502 core and the CPU bus decoder, and muxes address, rw and write data onto the bus.

## Interface
- No parameters.
- clk  in  1  system clock; one clk = one CPU cycle
- rst  in  1  reset, asynchronous, active-high
- cpu_addr  in  16  CPU core address
- cpu_rw  in  1  CPU core rw (1 = read)
- cpu_data_o  in  8  CPU core write data
- bus_data_i  in  8  bus read data; valid the cycle after the address is presented
- bus_addr  out  16  address to bus decoder
- bus_rw  out  1  rw to bus decoder
- bus_data_o  out  8  write data to bus decoder
- cpu_rdy  out  1  CPU RDY; 0 stalls the CPU on read cycles
- dma_active  out  1  1 while the DMA owns the bus (READ/WRITE/ALIGN/halt cycle)

## Operation
- States: IDLE, WAIT, ALIGN, READ, WRITE.
- Registers: page[7:0], idx[7:0], parity (toggles every clk).
- parity = 0 marks a "get" cycle.
- IDLE
  - Bus outputs pass the CPU signals through.
  - A cycle with cpu_rw=0 and cpu_addr==16'h4014 (exact match, no mirroring) latches page ← cpu_data_o and idx ← 0, then goes to WAIT.
- WAIT
  - cpu_rdy=0. Bus passes the CPU signals.
  - If cpu_rw=0, the CPU is still writing (up to 3 consecutive write cycles); stay in WAIT.
  - If cpu_rw=1, this cycle is the halt cycle. Next state is READ if parity=1, else ALIGN.
- ALIGN: one dummy cycle, bus passes the CPU signals, next state READ.
- READ
  - bus_addr={page,idx}, bus_rw=1.
  - Next state WRITE.
- WRITE
  - bus_addr=16'h2004, bus_rw=0, bus_data_o=bus_data_i (the data returned for the preceding READ).
  - If idx==8'hFF, go to IDLE. Otherwise idx←idx+1 (8-bit), go to READ.
- cpu_rdy=0 in WAIT, ALIGN, READ and WRITE.
- dma_active=1 in ALIGN, READ, WRITE, and in WAIT on the halt cycle (cpu_rw=1).
- $4014 writes outside IDLE are ignored; the CPU is halted at that point and cannot issue them.
- Page $20–$3F is copied as-is (the PPU register reads have side effects); no special casing.

## Timing
- Reset values: state=IDLE, page=0, idx=0, parity=0, cpu_rdy=1, dma_active=0. Bus outputs follow the CPU.
- parity=0 in the first cycle after rst deasserts.
- Trigger write in cycle T → cpu_rdy=0 from cycle T+1.
- Cycle count from the halt cycle to the last WRITE, inclusive:
  - 513 when the halt cycle has parity=1.
  - 514 when the halt cycle has parity=0.
  - Each added write cycle in WAIT adds one cycle.
- READ always occurs on parity=0 and WRITE on parity=1.
- cpu_rdy returns to 1 in the cycle after the final WRITE (idx=$FF). The CPU resumes its stalled read that cycle.
- Bus mux is combinational on state; no added latency on CPU pass-through.
- Reset mid-DMA:
  - Immediate IDLE and cpu_rdy=1.
  - No further $2004 writes.
  - OAM contents left partially written.

## Test plan
- Even alignment:
  - Stimulus: reset; RAM $0200+n=n; CPU writes $02 to $4014 so that the halt cycle has parity=1.
  - Response: cpu_rdy low for 513 cycles after the trigger cycle (plus any WAIT write cycles); 256 writes to $2004 carrying data $00..$FF in order, each preceded by a read of $02nn.
- Odd alignment: same as above, with the halt cycle at parity=0 → one ALIGN cycle, 514 cycles, identical data sequence.
- Write stretch: trigger followed by 2 more CPU write cycles → WAIT holds 2 cycles with bus passthrough (rw=0, CPU addresses), then the halt cycle; total stall grows by 2.
- ROM source: page $80 with cart bytes $80nn=~n → $2004 receives $FF..$00; bus_addr on READs runs $8000..$80FF.
- Reset mid-operation: assert rst after the 100th WRITE → cpu_rdy=1 and dma_active=0 immediately; after release the bus follows the CPU; a new $4014 write restarts from idx=0.
- Decode negatives: writes to $4015 and $C014, and a read of $4014 → no state change and cpu_rdy stays 1.
